// File: rtl/modbus_frame_tx_pkg.sv
// Shared types and constants for the Modbus RTU frame transmitter.
// State encoding, CRC parameters and payload limit.
package modbus_frame_tx_pkg;

  typedef enum logic [8:0] {
    IDLE   = 9'h001,
    GAP    = 9'h002,
    FETCH  = 9'h004,
    LOAD   = 9'h008,
    SEND   = 9'h010,
    WAIT   = 9'h020,
    CRC_LO = 9'h040,
    CRC_HI = 9'h080,
    DONE   = 9'h100
  } state_t;

  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC_POLY    = 16'hA001;
  localparam logic [7:0]  MAX_PAYLOAD = 8'd253;

  function automatic logic [15:0] crc16_byte(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/modbus_frame_tx_crc.sv
// CRC-16/MODBUS accumulator, one byte per enabled cycle.
// Clear has priority over enable.
module crc16_modbus
  import modbus_frame_tx_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        crc_clr,
  input  logic        crc_en,
  input  logic [7:0]  crc_din,
  output logic [15:0] crc_out
);

  logic [15:0] r_crc;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_crc <= CRC_INIT;
    end else if (crc_clr) begin
      r_crc <= CRC_INIT;
    end else if (crc_en) begin
      r_crc <= crc16_byte(r_crc, crc_din);
    end
  end

  assign crc_out = r_crc;

endmodule

// File: rtl/modbus_frame_tx.sv
// Modbus RTU frame sender: T3.5 gap, payload from buffer, CRC tail.
// Bytes go out through an external uart_byte_tx handshake.
module modbus_frame_tx
  import modbus_frame_tx_pkg::*;
#(
  parameter int CLK_FREQ  = 'd50000000,
  parameter int BAUD_RATE = 'd115200
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       frame_start,
  input  logic [7:0] frame_len,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err
);

  // 64-bit math: CLK_FREQ*385 overflows 32 bits at 50 MHz
  localparam logic [63:0] T35_W = (BAUD_RATE <= 19200)
    ? (64'(CLK_FREQ) * 64'd385) / (64'(BAUD_RATE) * 64'd10)
    : (64'(CLK_FREQ) * 64'd1750) / 64'd1000000;
  localparam logic [19:0] T35 = T35_W[19:0];

  state_t      r_state;
  state_t      w_next;
  logic [19:0] r_idle;
  logic [7:0]  r_len;
  logic [7:0]  r_idx;
  logic [7:0]  r_tx_data;
  logic        r_err;
  logic [15:0] w_crc;
  logic        w_len_ok;
  logic        w_accept;
  logic        w_reject;
  logic [8:0]  w_nidx;
  logic [8:0]  w_len9;

  assign w_len_ok = (frame_len != 8'd0) && (frame_len <= MAX_PAYLOAD);
  assign w_accept = (r_state == IDLE) && frame_start && w_len_ok;
  assign w_reject = (r_state == IDLE) && frame_start && !w_len_ok;
  assign w_nidx   = {1'b0, r_idx} + 9'd1;
  assign w_len9   = {1'b0, r_len};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (w_accept) w_next = GAP;
      GAP:    if (r_idle == T35) w_next = FETCH;
      FETCH:  w_next = LOAD;
      LOAD:   w_next = SEND;
      SEND:   w_next = WAIT;
      WAIT: begin
        if (tx_done) begin
          unique case (1'b1)
            (w_nidx <  w_len9):         w_next = FETCH;
            (w_nidx == w_len9):         w_next = CRC_LO;
            (w_nidx == w_len9 + 9'd1):  w_next = CRC_HI;
            (w_nidx >  w_len9 + 9'd1):  w_next = DONE;
            default:                    w_next = DONE;
          endcase
        end
      end
      CRC_LO: w_next = SEND;
      CRC_HI: w_next = SEND;
      DONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_idx walks payload bytes, then counts the two CRC bytes
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_idle    <= 20'd0;
      r_len     <= 8'd0;
      r_idx     <= 8'd0;
      r_tx_data <= 8'h00;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (tx_done) begin
        r_idle <= 20'd0;
      end else if (r_idle != T35) begin
        r_idle <= r_idle + 20'd1;
      end
      if (w_accept) begin
        r_len <= frame_len;
        r_idx <= 8'd0;
      end else if ((r_state == WAIT) && tx_done) begin
        r_idx <= r_idx + 8'd1;
      end
      if (r_state == LOAD) begin
        r_tx_data <= rd_data;
      end else if (r_state == CRC_LO) begin
        r_tx_data <= w_crc[7:0];
      end else if (r_state == CRC_HI) begin
        r_tx_data <= w_crc[15:8];
      end
    end
  end

  crc16_modbus u_crc (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .crc_clr  (w_accept),
    .crc_en   (r_state == LOAD),
    .crc_din  (rd_data),
    .crc_out  (w_crc)
  );

  assign rd_addr    = r_idx;
  assign tx_data    = r_tx_data;
  assign tx_start   = (r_state == SEND);
  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == DONE);
  assign frame_err  = r_err;

endmodule

// File: tb/tb_modbus_frame_tx.sv
// Bench for modbus_frame_tx: table vectors, random frames, reset cases.
// Line bytes and timing are judged against a frame-level model.
`timescale 1ns/1ps
module tb_modbus_frame_tx;

  localparam int CLK_FREQ  = 1000000;
  localparam int BAUD_RATE = 115200;
  localparam longint T35 = (BAUD_RATE <= 19200)
    ? (longint'(CLK_FREQ) * 11 * 35) / (longint'(BAUD_RATE) * 10)
    : (longint'(CLK_FREQ) * 1750) / 1000000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic [7:0] frame_len;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       busy;
  logic       frame_done;
  logic       frame_err;

  modbus_frame_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .frame_start (frame_start),
    .frame_len   (frame_len),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:255];
  logic [7:0] line [$];
  longint cyc = 0;
  longint last_done = -1;
  longint ref_cyc = 0;
  longint due = 0;
  bit     pend = 0;
  logic [7:0] held = 8'h00;
  int n_start = 0;
  int n_fd = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act,
                         input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  always @(posedge clk) rd_data <= mem[rd_addr];

  // Line monitor plus uart_byte_tx stand-in with random byte time
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend    = 0;
      tx_done = 1'b0;
    end else begin
      if (frame_done) begin
        n_fd++;
        last_done = -1;
      end
      if (frame_err) n_err++;
      if (tx_start) begin
        n_start++;
        line.push_back(tx_data);
        held = tx_data;
        if (last_done < 0) chk_rng("t35_gap", cyc - ref_cyc, T35, 64'h7fffffff);
        else chk_rng("byte_gap", cyc - last_done, 1, 4);
        pend = 1;
        due  = cyc + longint'($urandom_range(4, 12));
      end
      tx_done = 1'b0;
      if (pend && cyc == due) begin
        tx_done   = 1'b1;
        pend      = 0;
        last_done = cyc;
        ref_cyc   = cyc;
        chk("tx_data_stable", tx_data, held);
      end
    end
  end

  function automatic logic [15:0] ref_crc(input logic [7:0] b[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[i]) begin
      c = c ^ {8'h00, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic chk_reset_outs(input string nm);
    chk(nm, {tx_start, tx_data, rd_addr, busy, frame_done, frame_err}, 0);
  endtask

  task automatic run_frame(input int len, input logic [7:0] exp[$], input bit inject);
    int k;
    int d0;
    int e0;
    int errs;
    line.delete();
    d0 = n_fd;
    e0 = n_err;
    @(posedge clk); #1;
    frame_start = 1'b1;
    frame_len   = len[7:0];
    @(posedge clk); #1;
    frame_start = 1'b0;
    chk("busy_set", busy, 1);
    if (inject) begin
      k = 0;
      while (line.size() < 2 && k < 20000) begin @(posedge clk); k++; end
      #1 frame_start = 1'b1;
      frame_len = 8'd3;
      @(posedge clk); #1;
      frame_start = 1'b0;
    end
    k = 0;
    while (n_fd == d0 && k < T35 + (len + 2) * 20 + 200) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk("done_count", n_fd - d0, 1);
    chk("busy_after", busy, 0);
    chk("no_err", n_err - e0, 0);
    chk("line_len", line.size(), exp.size());
    errs = 0;
    for (int i = 0; i < exp.size(); i++) begin
      if (i >= line.size() || line[i] !== exp[i]) errs++;
    end
    chk("line_bytes_bad", errs, 0);
  endtask

  task automatic mem_frame(input int len, input bit inject);
    logic [7:0] e[$];
    logic [15:0] c;
    for (int i = 0; i < len; i++) e.push_back(mem[i]);
    c = ref_crc(e);
    e.push_back(c[7:0]);
    e.push_back(c[15:8]);
    run_frame(len, e, inject);
  endtask

  task automatic reject(input logic [7:0] len);
    int s0;
    int e0;
    s0 = n_start;
    e0 = n_err;
    @(posedge clk); #1;
    frame_start = 1'b1;
    frame_len   = len;
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    chk("err_pulse", frame_err, 1);
    chk("err_busy", busy, 0);
    @(negedge clk);
    chk("err_one_cycle", frame_err, 0);
    repeat (5) @(negedge clk);
    chk("err_no_tx", n_start - s0, 0);
    chk("err_count", n_err - e0, 1);
  endtask

  typedef struct {
    logic [7:0] len;
    bit         err;
    logic [7:0] b [8];
  } vec_t;

  vec_t tab [4];

  initial begin
    logic [7:0] e[$];
    int k;
    int s0;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    frame_len   = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    tab[0] = '{len: 8'd0,   err: 1'b1, b: '{default: 8'h00}};
    tab[1] = '{len: 8'd254, err: 1'b1, b: '{default: 8'h00}};
    tab[2] = '{len: 8'd255, err: 1'b1, b: '{default: 8'h00}};
    tab[3] = '{len: 8'd6,   err: 1'b0,
               b: '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A}};

    repeat (3) @(negedge clk);
    chk_reset_outs("reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    ref_cyc = cyc;
    last_done = -1;

    for (int t = 0; t < 4; t++) begin
      if (tab[t].err) begin
        reject(tab[t].len);
      end else begin
        e.delete();
        for (int i = 0; i < int'(tab[t].len); i++) mem[i] = tab[t].b[i];
        for (int i = 0; i < int'(tab[t].len) + 2; i++) e.push_back(tab[t].b[i]);
        run_frame(int'(tab[t].len), e, 1'b0);
      end
    end

    repeat (100) @(posedge clk);
    mem[0] = 8'hC2; mem[1] = 8'hB3; mem[2] = 8'hA4; mem[3] = 8'h95;
    mem_frame(4, 1'b0);

    for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
    mem_frame(8, 1'b1);

    for (int r = 0; r < 4; r++) begin
      k = $urandom_range(1, 12);
      for (int i = 0; i < k; i++) mem[i] = 8'($urandom);
      mem_frame(k, 1'b0);
    end

    mem[0] = 8'($urandom);
    mem_frame(1, 1'b0);
    for (int i = 0; i < 253; i++) mem[i] = 8'($urandom);
    mem_frame(253, 1'b0);

    for (int i = 0; i < 6; i++) mem[i] = 8'($urandom);
    s0 = n_start;
    @(posedge clk); #1;
    frame_start = 1'b1;
    frame_len   = 8'd6;
    @(posedge clk); #1;
    frame_start = 1'b0;
    k = 0;
    while (n_start - s0 < 3 && k < T35 + 500) begin @(posedge clk); k++; end
    chk("mid_reset_reached", n_start - s0, 3);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outs("mid_reset_outputs");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ref_cyc = cyc;
    last_done = -1;
    @(negedge clk);
    chk_reset_outs("post_reset_outputs");

    for (int i = 0; i < 5; i++) mem[i] = 8'($urandom);
    mem_frame(5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
